// File: rtl/matmul_seq_pkg.sv
// Shared definitions for the matmul stage sequencer.
//   seq_state_t  : sequencer FSM states
//   stage_idx_w  : width of a stage index (error_stage, stage pointer), never below 1
package matmul_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRIG   = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } seq_state_t;

  // A single-stage chain still needs a 1-bit index port.
  function automatic int stage_idx_w(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/seq_next_stage.sv
// Combinational priority encoder over the stage enable mask.
//   mask       : enabled stages
//   ptr        : current stage index
//   next_idx   : lowest enabled index strictly above ptr (valid when none_above=0)
//   first_idx  : lowest enabled index (valid when any_en=1)
//   none_above : no enabled stage above ptr, i.e. the pass ends after ptr
//   any_en     : at least one stage enabled
module seq_next_stage #(
  parameter int NUM_STAGES = 4,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_STAGES-1:0] mask,
  input  logic [IDX_W-1:0]      ptr,
  output logic [IDX_W-1:0]      next_idx,
  output logic [IDX_W-1:0]      first_idx,
  output logic                  none_above,
  output logic                  any_en
);

  // Scanning from the top down lets the last hit be the lowest index.
  always_comb begin
    next_idx   = '0;
    first_idx  = '0;
    none_above = 1'b1;
    any_en     = |mask;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_idx = IDX_W'(i);
      end
      if (mask[i] && (i > int'(ptr))) begin
        next_idx   = IDX_W'(i);
        none_above = 1'b0;
      end
    end
  end

endmodule

// File: rtl/matmul_stage_sequencer.sv
// Host-side sequencer running a chain of Neurram sub-operations in order for a
// programmable number of passes, with per-stage enable masking, a per-stage
// watchdog and abort support.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : run request (IDLE only); latches iterations/stage_en/timeout
//   abort         : cancel the run in progress (TRIG/WAIT only)
//   iterations    : pass count, 0 behaves as 1
//   stage_en      : per-stage enable mask
//   timeout       : per-stage cycle limit, 0 disables the watchdog
//   stage_idle    : idle status from each sub-controller
//   stage_trigger : one-hot trigger to the active stage
//   idle, done    : no run active / one-cycle end-of-run pulse
//   error         : watchdog expired in the last run (sticky until next start)
//   error_stage   : stage that timed out
//   iter_count    : passes completed in the current or last run
module matmul_stage_sequencer
  import matmul_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int ITER_W     = 8,
  parameter int TIMEOUT_W  = 16,
  localparam int IDX_W     = stage_idx_w(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITER_W-1:0]     iterations,
  input  logic [NUM_STAGES-1:0] stage_en,
  input  logic [TIMEOUT_W-1:0]  timeout,
  input  logic [NUM_STAGES-1:0] stage_idle,
  output logic [NUM_STAGES-1:0] stage_trigger,
  output logic                  idle,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      error_stage,
  output logic [ITER_W-1:0]     iter_count
);

  seq_state_t state, next_state;

  logic [ITER_W-1:0]     cfg_iter;
  logic [NUM_STAGES-1:0] cfg_en;
  logic [TIMEOUT_W-1:0]  cfg_timeout;
  logic [IDX_W-1:0]      ptr, ptr_next;
  logic [TIMEOUT_W-1:0]  wdog, wdog_next;
  logic [ITER_W-1:0]     iter_next;
  logic                  error_next;
  logic [IDX_W-1:0]      error_stage_next;
  logic [NUM_STAGES-1:0] trigger_d;
  logic                  idle_d, done_d, launch;

  logic [NUM_STAGES-1:0] enc_mask;
  logic [IDX_W-1:0]      next_idx, first_idx;
  logic                  none_above, any_en;
  logic [ITER_W:0]       iter_plus1, iter_target;
  logic                  expire;

  assign launch = (state == S_IDLE) && start;

  // In IDLE the configuration is not latched yet, so the first stage of a new
  // run is taken straight from the stage_en input.
  assign enc_mask = (state == S_IDLE) ? stage_en : cfg_en;

  seq_next_stage #(
    .NUM_STAGES (NUM_STAGES),
    .IDX_W      (IDX_W)
  ) u_next_stage (
    .mask       (enc_mask),
    .ptr        (ptr),
    .next_idx   (next_idx),
    .first_idx  (first_idx),
    .none_above (none_above),
    .any_en     (any_en)
  );

  // Pass-end test is done one bit wider so iter_count+1 cannot wrap.
  assign iter_plus1  = {1'b0, iter_count} + (ITER_W+1)'(1);
  assign iter_target = (cfg_iter == '0) ? (ITER_W+1)'(1) : {1'b0, cfg_iter};
  // wdog counts cycles already spent, so this cycle is the timeout-th one.
  assign expire      = (cfg_timeout != '0) && (wdog == cfg_timeout - TIMEOUT_W'(1));

  // Priority inside TRIG/WAIT: abort, then completion, then watchdog expiry,
  // then acknowledge. Outputs are decoded from next_state so they line up
  // with the registered state.
  always_comb begin
    next_state       = state;
    ptr_next         = ptr;
    wdog_next        = wdog;
    iter_next        = iter_count;
    error_next       = error;
    error_stage_next = error_stage;
    case (state)
      S_IDLE: begin
        if (start) begin
          iter_next        = '0;
          error_next       = 1'b0;
          error_stage_next = '0;
          wdog_next        = '0;
          if (!any_en) begin
            next_state = S_FINISH;
          end else begin
            ptr_next   = first_idx;
            next_state = S_TRIG;
          end
        end
      end
      S_TRIG, S_WAIT: begin
        wdog_next = (&wdog) ? wdog : wdog + TIMEOUT_W'(1);
        if (abort) begin
          next_state = S_FINISH;
        end else if ((state == S_WAIT) && stage_idle[ptr]) begin
          wdog_next = '0;
          if (!none_above) begin
            ptr_next   = next_idx;
            next_state = S_TRIG;
          end else begin
            iter_next = (&iter_count) ? iter_count : iter_count + ITER_W'(1);
            if (iter_plus1 >= iter_target) begin
              next_state = S_FINISH;
            end else begin
              ptr_next   = first_idx;
              next_state = S_TRIG;
            end
          end
        end else if (expire) begin
          error_next       = 1'b1;
          error_stage_next = ptr;
          next_state       = S_FINISH;
        end else if ((state == S_TRIG) && !stage_idle[ptr]) begin
          next_state = S_WAIT;
        end
      end
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase

    trigger_d = (next_state == S_TRIG) ? (NUM_STAGES'(1) << ptr_next) : '0;
    idle_d    = (next_state == S_IDLE);
    done_d    = (next_state == S_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      ptr           <= '0;
      wdog          <= '0;
      cfg_iter      <= '0;
      cfg_en        <= '0;
      cfg_timeout   <= '0;
      iter_count    <= '0;
      error         <= 1'b0;
      error_stage   <= '0;
      stage_trigger <= '0;
      idle          <= 1'b1;
      done          <= 1'b0;
    end else begin
      state         <= next_state;
      ptr           <= ptr_next;
      wdog          <= wdog_next;
      iter_count    <= iter_next;
      error         <= error_next;
      error_stage   <= error_stage_next;
      stage_trigger <= trigger_d;
      idle          <= idle_d;
      done          <= done_d;
      if (launch) begin
        cfg_iter    <= iterations;
        cfg_en      <= stage_en;
        cfg_timeout <= timeout;
      end
    end
  end

endmodule

// File: tb/tb_matmul_stage_sequencer.sv
// Self-checking bench for matmul_stage_sequencer (NUM_STAGES=4).
// Each stage is modelled as a sub-controller that drops stage_idle on the
// first negedge its trigger is seen and raises it again after BUSY cycles,
// unless its hang bit is set (it then never acknowledges).
module tb_matmul_stage_sequencer;

  localparam int BUSY = 5;

  typedef struct {
    logic [7:0]  iter;
    logic [3:0]  en;
    logic [15:0] to;
    logic [3:0]  hang;
    logic [3:0]  exp_trig0;
    logic [7:0]  exp_iter;
    logic        exp_err;
    logic [1:0]  exp_err_stage;
    int          exp_len;
    logic [31:0] exp_seq;
    int          exp_tcyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  iterations = '0;
  logic [3:0]  stage_en = '0;
  logic [15:0] timeout = '0;
  logic [3:0]  stage_idle = 4'hF;
  logic [3:0]  stage_trigger;
  logic        idle, done, error;
  logic [1:0]  error_stage;
  logic [7:0]  iter_count;

  logic [3:0]  hang = '0;
  int          ph [4];
  int          cnt [4];
  logic [3:0]  prev_trig = '0;
  int          trig_log [$];
  int          trig_cycles = 0;
  int          done_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl [7];

  always #5 clk = ~clk;

  matmul_stage_sequencer #(
    .NUM_STAGES (4),
    .ITER_W     (8),
    .TIMEOUT_W  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .iterations    (iterations),
    .stage_en      (stage_en),
    .timeout       (timeout),
    .stage_idle    (stage_idle),
    .stage_trigger (stage_trigger),
    .idle          (idle),
    .done          (done),
    .error         (error),
    .error_stage   (error_stage),
    .iter_count    (iter_count)
  );

  // Recorder for trigger order/duration and done pulses, plus the stage models.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (stage_trigger[i] && !prev_trig[i]) trig_log.push_back(i);
      if (stage_trigger[i]) trig_cycles++;
    end
    prev_trig = stage_trigger;
    if (done) done_cnt++;
    if (rst) begin
      stage_idle = 4'hF;
      for (int i = 0; i < 4; i++) ph[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ph[i] == 0) begin
          if (stage_trigger[i] && !hang[i]) begin
            stage_idle[i] = 1'b0;
            cnt[i] = BUSY;
            ph[i] = 1;
          end
        end else if (cnt[i] > 1) begin
          cnt[i]--;
        end else begin
          stage_idle[i] = 1'b1;
          ph[i] = 0;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // kind 0: first pass completed; kind 1: sequencer in WAIT
  task automatic wait_for(input int kind, input string name);
    int n;
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < 300) begin
      if (kind == 0) hit = (iter_count == 8'd1);
      else           hit = (!idle && !done && stage_trigger == 4'b0000);
      if (!hit) begin
        step();
        n++;
      end
    end
    if (!hit) check_output({name, " wait expired"}, 32'd0, 32'd1);
  endtask

  // Runs one table vector from start to the idle cycle after done.
  task automatic apply_stimulus(input vec_t v, input int idx);
    int log0, tc0, dc0, n, len;
    logic [31:0] seq;
    hang       = v.hang;
    iterations = v.iter;
    stage_en   = v.en;
    timeout    = v.to;
    log0 = trig_log.size();
    tc0  = trig_cycles;
    dc0  = done_cnt;
    start = 1'b1;
    step();
    start      = 1'b0;
    iterations = 8'hFF;
    stage_en   = ~v.en;
    timeout    = 16'd3;
    check_output($sformatf("v%0d first trigger", idx), 32'(stage_trigger), 32'(v.exp_trig0));
    check_output($sformatf("v%0d idle after start", idx), 32'(idle), 32'd0);
    n = 0;
    while (!done && n < 2000) begin
      step();
      n++;
    end
    if (!done) check_output($sformatf("v%0d done wait expired", idx), 32'd0, 32'd1);
    check_output($sformatf("v%0d iter_count", idx), 32'(iter_count), 32'(v.exp_iter));
    check_output($sformatf("v%0d error", idx), 32'(error), 32'(v.exp_err));
    check_output($sformatf("v%0d error_stage", idx), 32'(error_stage), 32'(v.exp_err_stage));
    len = trig_log.size() - log0;
    seq = '0;
    for (int j = 0; j < len && j < 16; j++) seq[2*j +: 2] = 2'(trig_log[log0 + j]);
    check_output($sformatf("v%0d trigger count", idx), 32'(len), 32'(v.exp_len));
    check_output($sformatf("v%0d trigger order", idx), seq, v.exp_seq);
    check_output($sformatf("v%0d trigger cycles", idx), 32'(trig_cycles - tc0), 32'(v.exp_tcyc));
    check_output($sformatf("v%0d done pulses", idx), 32'(done_cnt - dc0), 32'd1);
    step();
    check_output($sformatf("v%0d idle after done", idx), 32'(idle), 32'd1);
    check_output($sformatf("v%0d done low after", idx), 32'(done), 32'd0);
    settle(10);
  endtask

  initial begin
    //           iter    en       to      hang     trig0    exp_it err   est   len seq        tcyc
    tbl[0] = '{8'd2, 4'b1011, 16'd0,  4'b0000, 4'b0001, 8'd2, 1'b0, 2'd0, 6, 32'hD34, 6};
    tbl[1] = '{8'd0, 4'b1111, 16'd0,  4'b0000, 4'b0001, 8'd1, 1'b0, 2'd0, 4, 32'hE4,  4};
    tbl[2] = '{8'd1, 4'b1111, 16'd0,  4'b0000, 4'b0001, 8'd1, 1'b0, 2'd0, 4, 32'hE4,  4};
    tbl[3] = '{8'd3, 4'b0000, 16'd0,  4'b0000, 4'b0000, 8'd0, 1'b0, 2'd0, 0, 32'h0,   0};
    tbl[4] = '{8'd1, 4'b0110, 16'd10, 4'b0010, 4'b0010, 8'd0, 1'b1, 2'd1, 1, 32'h1,  10};
    tbl[5] = '{8'd3, 4'b1000, 16'd20, 4'b0000, 4'b1000, 8'd3, 1'b0, 2'd0, 3, 32'h3F,  3};
    tbl[6] = '{8'd2, 4'b0100, 16'd0,  4'b0000, 4'b0100, 8'd2, 1'b0, 2'd0, 2, 32'hA,   2};

    // Reset values
    step();
    check_output("reset idle", 32'(idle), 32'd1);
    check_output("reset trigger", 32'(stage_trigger), 32'd0);
    check_output("reset done", 32'(done), 32'd0);
    check_output("reset error", 32'(error), 32'd0);
    check_output("reset error_stage", 32'(error_stage), 32'd0);
    check_output("reset iter_count", 32'(iter_count), 32'd0);
    rst = 1'b0;
    settle(2);

    for (int i = 0; i < 7; i++) apply_stimulus(tbl[i], i);

    // Watchdog error is cleared by the next start
    apply_stimulus(tbl[4], 40);
    hang       = 4'b0000;
    iterations = 8'd1;
    stage_en   = 4'b0001;
    timeout    = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("error cleared by start", 32'(error), 32'd0);
    check_output("error_stage cleared by start", 32'(error_stage), 32'd0);
    wait_for(1, "clear run");
    settle(30);
    check_output("clear run back to idle", 32'(idle), 32'd1);

    // Abort in WAIT during pass 2 of 3, with a stray start mid-run
    iterations = 8'd3;
    stage_en   = 4'b0011;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_for(0, "abort pass1");
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("stray start iter_count", 32'(iter_count), 32'd1);
    check_output("stray start idle", 32'(idle), 32'd0);
    wait_for(1, "abort wait state");
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_output("abort done", 32'(done), 32'd1);
    check_output("abort trigger", 32'(stage_trigger), 32'd0);
    check_output("abort iter_count", 32'(iter_count), 32'd1);
    check_output("abort error", 32'(error), 32'd0);
    step();
    check_output("abort idle after", 32'(idle), 32'd1);
    settle(10);

    // Asynchronous reset in WAIT of pass 2, then a fresh run
    iterations = 8'd2;
    stage_en   = 4'b0001;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_for(0, "reset pass1");
    wait_for(1, "reset wait state");
    rst = 1'b1;
    #1;
    check_output("async reset idle", 32'(idle), 32'd1);
    check_output("async reset trigger", 32'(stage_trigger), 32'd0);
    check_output("async reset done", 32'(done), 32'd0);
    check_output("async reset iter_count", 32'(iter_count), 32'd0);
    check_output("async reset error", 32'(error), 32'd0);
    step();
    rst = 1'b0;
    settle(3);
    apply_stimulus(tbl[0], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global time limit: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/matmul_stage_sequencer.md
# matmul_stage_sequencer

Parametrised host-side sequencer that runs a chain of up to NUM_STAGES Neurram sub-operations (e.g. unsigned matmul, NMLO, ADC readout) in order for a programmable number of passes. It sits between the host trigger/status registers and the per-operation controllers. It adds three things over the fixed two-stage sequencer:

- per-stage enable masking
- a per-stage watchdog timeout with error reporting
- abort and completion-status outputs

## Interface

Parameters:

- NUM_STAGES, 4, number of chained sub-operations (≥1)
- ITER_W, 8, width of the pass count
- TIMEOUT_W, 16, width of the per-stage watchdog limit

Ports:

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  run request, sampled only in IDLE
- abort  in  1  cancel the run in progress
- iterations  in  ITER_W  number of passes; 0 is treated as 1
- stage_en  in  NUM_STAGES  bit i enables stage i
- timeout  in  TIMEOUT_W  per-stage cycle limit; 0 disables the watchdog
- stage_idle  in  NUM_STAGES  idle status from each sub-controller
- stage_trigger  out  NUM_STAGES  one-hot trigger to the active stage
- idle  out  1  high when no run is active
- done  out  1  one-cycle pulse at the end of every run (normal, timeout or abort)
- error  out  1  watchdog expired in the last run; sticky until the next start
- error_stage  out  $clog2(NUM_STAGES) (min 1)  index of the stage that timed out
- iter_count  out  ITER_W  passes completed in the current or last run

## Operation

States:

- IDLE
- TRIG (trigger held, waiting for acknowledge)
- WAIT (waiting for stage completion)
- FINISH (one cycle; drives done)

Run start:

- In IDLE, start=1 latches iterations, stage_en and timeout into internal copies; inputs may then change freely.
- Clears error, error_stage and iter_count.
- If the latched stage_en is all-zero: go to FINISH (no triggers issued, iter_count stays 0).
- Otherwise: ptr = lowest enabled stage, go to TRIG.

Stage handshake:

- TRIG: stage_trigger[ptr]=1. stage_idle[ptr]=0 is the acknowledge → WAIT.
- WAIT: trigger low. stage_idle[ptr]=1 → stage complete.
- On completion, ptr moves to the lowest enabled index above ptr, then TRIG.
- If no enabled index lies above ptr, the pass ends:
  - iter_count increments.
  - If iter_count+1 ≥ max(iterations,1) → FINISH.
  - Otherwise ptr = lowest enabled stage → TRIG.

Watchdog:

- A counter clears on every TRIG entry and increments each cycle in TRIG or WAIT.
- If timeout≠0 and the count reaches timeout before completion:
  - error=1, error_stage=ptr
  - trigger dropped, → FINISH

Abort and finish:

- abort=1 in TRIG or WAIT → FINISH next cycle with the trigger dropped. iter_count keeps the completed passes and error is unchanged.
- abort in IDLE or FINISH is ignored.
- FINISH → IDLE unconditionally.
- start outside IDLE is ignored.

Arithmetic:

- iter_count saturates at 2^ITER_W−1.
- The watchdog counter is TIMEOUT_W bits and never wraps: expiry occurs first.

## Timing

- All outputs are registered and decoded from next_state, so they align with state.
- Reset values: idle=1; stage_trigger=0; done=0; error=0; error_stage=0; iter_count=0; state=IDLE.
- start sampled at edge k → stage_trigger[first] high and idle low from cycle k+1.
- Completion seen at edge k → next stage trigger (or done) at cycle k+1. There are no dead cycles between stages.
- done high exactly one cycle (FINISH); idle returns high the following cycle.
- Simultaneous events:
  - abort together with stage completion or timeout: abort wins and error is not set.
  - Timeout and completion on the same edge: completion wins.
- A minimum-length stage (ack and idle each one cycle) costs 2 cycles.
- Asynchronous rst at any point returns every output to its reset value immediately.

## Structure

- Shared package matmul_seq_pkg:
  - state enum (IDLE, TRIG, WAIT, FINISH)
  - helper function giving the width of error_stage
- Sub-module seq_next_stage: combinational priority encoder.
  - Inputs: mask, ptr.
  - Outputs: next enabled index above ptr, lowest enabled index, a "none-above" flag, an "any-enabled" flag.
- The top level holds the FSM, latched configuration, watchdog and counters.

## Test plan

- NUM_STAGES=4, stage_en=4'b1011, iterations=2, stages ack after 1 cycle and finish after 5 → trigger order 0,1,3,0,1,3; stage 2 never triggered; iter_count=2; single done; error=0.
- iterations=0 and iterations=1, all stages enabled → exactly one pass each; iter_count=1.
- stage_en=0, start → done at cycle k+1 after start, no triggers, iter_count=0.
- timeout=10, stage 1 never acknowledges → trigger[1] high 10 cycles then drops; error=1, error_stage=1, done pulse; next start clears error.
- abort in WAIT during pass 2 of 3 → trigger low, done next cycle, iter_count=1, error=0; start pulses during the run have no effect.
- rst asserted mid-WAIT → all outputs at reset values asynchronously; a fresh start runs normally.
